// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge magnitude over a 4-px/word greyscale frame in shared memory.
// Define SOBEL_THRESH_EN to binarise each output pixel against THRESH.
module sobel_edge #(
   parameter int IMG_W    = 352,
   parameter int IMG_H    = 288,
   parameter int SRC_BASE = 0,
   parameter int DST_BASE = 25344
`ifdef SOBEL_THRESH_EN
   ,parameter int THRESH  = 128
`endif
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] addr,
   input  logic [31:0] dataR,
   output logic [31:0] dataW,
   output logic        en,
   output logic        we,
   input  logic        start,
   output logic        finish
);
   localparam logic [15:0] WC16 = 16'(IMG_W / 4);
   localparam logic [15:0] WCM1 = 16'(IMG_W / 4 - 1);
   localparam logic [15:0] HM1  = 16'(IMG_H - 1);
   localparam logic [15:0] SRC16 = 16'(SRC_BASE);
   localparam logic [15:0] DST16 = 16'(DST_BASE);

   typedef enum logic [3:0] {
      IDLE = 4'd0, ZROW = 4'd1, LD0 = 4'd2, LD1 = 4'd3, LD2 = 4'd4,
      LDC  = 4'd5, SHZ  = 4'd6, WR  = 4'd7, FIN = 4'd8
   } state_t;

   state_t            state_r, state_s;
   logic [15:0]       row_r, row_s;
   logic [15:0]       col_r, col_s;
   logic              clear_s;
   // Each window row is {R, M, L}; byte j covers pixel 4*(col-1)+j-4 relative to M.
   logic [2:0][95:0]  win_r;
   logic [31:0]       top_r, mid_r;
   logic [31:0]       pix_raw_s, pix_word_s;

   function automatic logic [7:0] sobel_px(input logic [7:0] a00, a01, a02, a10,
                                           input logic [7:0] a12, a20, a21, a22);
      logic [11:0] xr, xl, yb, yt, ax, ay, mag;
      xr  = {4'd0, a02} + {3'd0, a12, 1'b0} + {4'd0, a22};
      xl  = {4'd0, a00} + {3'd0, a10, 1'b0} + {4'd0, a20};
      yb  = {4'd0, a20} + {3'd0, a21, 1'b0} + {4'd0, a22};
      yt  = {4'd0, a00} + {3'd0, a01, 1'b0} + {4'd0, a02};
      ax  = (xr >= xl) ? (xr - xl) : (xl - xr);
      ay  = (yb >= yt) ? (yb - yt) : (yt - yb);
      mag = ax + ay;
`ifdef SOBEL_THRESH_EN
      sobel_px = (mag >= 12'(THRESH)) ? 8'hFF : 8'h00;
`else
      sobel_px = (mag > 12'd255) ? 8'hFF : mag[7:0];
`endif
   endfunction

   // Next-state and counter logic
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      col_s   = col_r;
      clear_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s = ZROW;
               row_s   = 16'd0;
               col_s   = 16'd0;
            end else begin
               state_s = IDLE;
            end
         end
         ZROW: begin
            if (col_r == WCM1) begin
               col_s = 16'd0;
               if (row_r == 16'd0) begin
                  row_s   = 16'd1;
                  clear_s = 1'b1;
                  state_s = LD0;
               end else begin
                  state_s = FIN;
               end
            end else begin
               col_s = col_r + 16'd1;
            end
         end
         LD0: state_s = LD1;
         LD1: state_s = LD2;
         LD2: state_s = LDC;
         LDC: begin
            if (col_r == 16'd0) begin
               col_s   = 16'd1;
               state_s = LD0;
            end else begin
               col_s   = col_r - 16'd1;
               state_s = WR;
            end
         end
         WR: begin
            if (col_r + 16'd2 <= WCM1) begin
               col_s   = col_r + 16'd2;
               state_s = LD0;
            end else if (col_r + 16'd1 == WCM1) begin
               state_s = SHZ;
            end else begin
               col_s   = 16'd0;
               row_s   = row_r + 16'd1;
               clear_s = 1'b1;
               state_s = (row_r + 16'd1 == HM1) ? ZROW : LD0;
            end
         end
         SHZ: begin
            col_s   = col_r + 16'd1;
            state_s = WR;
         end
         FIN: begin
            if (!start) begin
               state_s = IDLE;
            end else begin
               state_s = FIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         row_r   <= 16'd0;
         col_r   <= 16'd0;
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         col_r   <= col_s;
      end
   end

   // Window capture: rows r-1 and r are staged until the row r+1 word arrives
   always_ff @(posedge clk) begin
      if (reset) begin
         win_r <= '0;
         top_r <= 32'd0;
         mid_r <= 32'd0;
      end else begin
         if (clear_s) begin
            win_r <= '0;
         end else if (state_r == LDC) begin
            win_r <= {{dataR, win_r[2][95:32]}, {mid_r, win_r[1][95:32]}, {top_r, win_r[0][95:32]}};
         end else if (state_r == SHZ) begin
            win_r <= {{32'd0, win_r[2][95:32]}, {32'd0, win_r[1][95:32]}, {32'd0, win_r[0][95:32]}};
         end
         if (state_r == LD1) begin
            top_r <= dataR;
         end
         if (state_r == LD2) begin
            mid_r <= dataR;
         end
      end
   end

   // Sobel kernel on the four pixels of the centre word, with frame border zeroed
   always_comb begin
      pix_raw_s = 32'd0;
      for (int i = 0; i < 4; i++) begin
         pix_raw_s[8*i +: 8] = sobel_px(
            win_r[0][8*(3+i) +: 8], win_r[0][8*(4+i) +: 8], win_r[0][8*(5+i) +: 8],
            win_r[1][8*(3+i) +: 8], win_r[1][8*(5+i) +: 8],
            win_r[2][8*(3+i) +: 8], win_r[2][8*(4+i) +: 8], win_r[2][8*(5+i) +: 8]);
      end
      pix_word_s         = pix_raw_s;
      pix_word_s[7:0]    = (col_r == 16'd0) ? 8'd0 : pix_raw_s[7:0];
      pix_word_s[31:24]  = (col_r == WCM1) ? 8'd0 : pix_raw_s[31:24];
   end

   // Bus outputs decoded from state and counters
   always_comb begin
      addr   = 16'd0;
      dataW  = 32'd0;
      en     = 1'b0;
      we     = 1'b0;
      finish = 1'b0;
      case (state_r)
         ZROW: begin
            en   = 1'b1;
            we   = 1'b1;
            addr = DST16 + row_r * WC16 + col_r;
         end
         LD0: begin
            en   = 1'b1;
            addr = SRC16 + (row_r - 16'd1) * WC16 + col_r;
         end
         LD1: begin
            en   = 1'b1;
            addr = SRC16 + row_r * WC16 + col_r;
         end
         LD2: begin
            en   = 1'b1;
            addr = SRC16 + (row_r + 16'd1) * WC16 + col_r;
         end
         WR: begin
            en    = 1'b1;
            we    = 1'b1;
            addr  = DST16 + row_r * WC16 + col_r;
            dataW = pix_word_s;
         end
         FIN:     finish = 1'b1;
         default: finish = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_sobel_edge.sv
// Scoreboard bench for sobel_edge on a reduced 32x12 frame with a behavioural Sobel model.
module tb_sobel_edge;
   localparam int W    = 32;
   localparam int H    = 12;
   localparam int WC   = W / 4;
   localparam int SRC  = 0;
   localparam int DST  = 512;
   localparam int NW   = WC * H;
   localparam int BUSY = 2 * WC + (H - 2) * (4 + 5 * (WC - 1) + 2);

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr;
   logic [31:0] dataR = 32'd0;
   logic [31:0] dataW;
   logic        en, we;
   logic        start = 1'b0;
   logic        finish;

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   int          img [H][W];
   logic [31:0] src_mem [NW];
   logic [31:0] dst_mem [NW];
   int          checks = 0;
   int          errors = 0;

   sobel_edge #(.IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
      .clk(clk), .reset(reset), .addr(addr), .dataR(dataR), .dataW(dataW),
      .en(en), .we(we), .start(start), .finish(finish)
   );

   always #5 clk = ~clk;

   // Shared memory: one-cycle read latency, writes captured into dst_mem
   always @(posedge clk) begin
      if (en && !we && int'(addr) - SRC >= 0 && int'(addr) - SRC < NW) dataR <= src_mem[int'(addr) - SRC];
      if (en && we && int'(addr) - DST >= 0 && int'(addr) - DST < NW) dst_mem[int'(addr) - DST] <= dataW;
   end

   function automatic logic [7:0] ref_px(int r, int x);
      int gx, gy, mag;
      if (r == 0 || r == H - 1 || x == 0 || x == W - 1) return 8'd0;
      gx = (img[r-1][x+1] + 2 * img[r][x+1] + img[r+1][x+1])
         - (img[r-1][x-1] + 2 * img[r][x-1] + img[r+1][x-1]);
      gy = (img[r+1][x-1] + 2 * img[r+1][x] + img[r+1][x+1])
         - (img[r-1][x-1] + 2 * img[r-1][x] + img[r-1][x+1]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
      return (mag >= 128) ? 8'hFF : 8'h00;
`else
      return (mag > 255) ? 8'hFF : 8'(mag);
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every bus write is matched against the next expected raster-order write
   always @(negedge clk) begin
      if (!reset) begin
         if (en && we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: addr %0h data %0h, no write expected", addr, dataW);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (addr !== e.a || dataW !== e.d) begin
                  errors++;
                  $display("FAIL write: addr %0h data %08h expected addr %0h data %08h", addr, dataW, e.a, e.d);
               end
            end
         end
         if (!we) check("dataW_idle", 64'(dataW), 64'd0);
         if (en && !we) check("read_range", 64'(int'(addr) >= SRC && int'(addr) < SRC + NW), 64'd1);
      end
   end

   // mode 0: constant 0x80, 1: vertical step, 2: single pixel, 3: random, 4: random 0/255
   task automatic load_frame(input int mode);
      for (int r = 0; r < H; r++) begin
         for (int x = 0; x < W; x++) begin
            case (mode)
               0:       img[r][x] = 128;
               1:       img[r][x] = (x < W / 2) ? 0 : 255;
               2:       img[r][x] = (r == 5 && x == 9) ? 64 : 0;
               3:       img[r][x] = int'($urandom_range(0, 255));
               default: img[r][x] = ($urandom_range(0, 1) == 1) ? 255 : 0;
            endcase
         end
      end
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < WC; c++) begin
            for (int i = 0; i < 4; i++) src_mem[r * WC + c][8*i +: 8] = 8'(img[r][4*c+i]);
         end
      end
   endtask

   task automatic push_expected();
      wr_t e;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < WC; c++) begin
            e.a = 16'(DST + r * WC + c);
            for (int i = 0; i < 4; i++) e.d[8*i +: 8] = ref_px(r, 4 * c + i);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_frame(input bit pulse_start, input int hold);
      int n;
      push_expected();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (finish !== 1'b1 && n < BUSY + 64) begin
         if (pulse_start && n == 40) start = 1'b0;
         if (pulse_start && n == 43) start = 1'b1;
         @(posedge clk); #1; n++;
      end
      check("finish_latency", 64'(n), 64'(BUSY));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("finish_held", 64'(finish), 64'd1);
      end
      start = 1'b0;
      @(posedge clk); #1;
      check("finish_drop", 64'(finish), 64'd0);
      check("idle_no_bus", 64'(en), 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_en", 64'(en), 64'd0);
      check("rst_we", 64'(we), 64'd0);
      check("rst_finish", 64'(finish), 64'd0);
      check("rst_addr", 64'(addr), 64'd0);
      check("rst_dataW", 64'(dataW), 64'd0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("idle_without_start", 64'(en), 64'd0);

      load_frame(0);
      run_frame(1'b0, 0);

      load_frame(1);
      run_frame(1'b0, 0);
      check("step_left", 64'(dst_mem[1 * WC + W / 8 - 1]), 64'h00000000FF000000);
      check("step_right", 64'(dst_mem[1 * WC + W / 8]), 64'h00000000000000FF);

      load_frame(2);
      run_frame(1'b0, 0);
`ifdef SOBEL_THRESH_EN
      check("dot_row", 64'(dst_mem[5 * WC + 2]), 64'h0000000000FF00FF);
      check("dot_above", 64'(dst_mem[4 * WC + 2]), 64'h0000000000FFFFFF);
      check("dot_below", 64'(dst_mem[6 * WC + 2]), 64'h0000000000FFFFFF);
`else
      check("dot_row", 64'(dst_mem[5 * WC + 2]), 64'h0000000000800080);
      check("dot_above", 64'(dst_mem[4 * WC + 2]), 64'h0000000000808080);
      check("dot_below", 64'(dst_mem[6 * WC + 2]), 64'h0000000000808080);
`endif
      check("dot_other", 64'(dst_mem[5 * WC + 3]), 64'd0);

      // Abort a frame with a one-cycle reset, then rerun from scratch
      load_frame(0);
      push_expected();
      @(negedge clk); start = 1'b1;
      repeat (100) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("abort_en", 64'(en), 64'd0);
      check("abort_we", 64'(we), 64'd0);
      reset = 1'b0;
      start = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      check("abort_idle", 64'(en), 64'd0);
      run_frame(1'b0, 0);

      load_frame(3);
      run_frame(1'b1, 6);
      load_frame(3);
      run_frame(1'b0, 0);
      load_frame(4);
      run_frame(1'b0, 2);

      repeat (4) @(posedge clk);
      check("final_queue", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
